// File: rtl/dz_pkg.sv
// Shared types and constants for the dot-matrix countdown display blocks.
package dz_pkg;

    // Countdown sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Colour phase encodings driven to the matrix (3 is never used)
    localparam logic [1:0] COL_RED    = 2'd0;
    localparam logic [1:0] COL_GREEN  = 2'd1;
    localparam logic [1:0] COL_YELLOW = 2'd2;

    // Rows in the 8x8 matrix; row_sel is 3 bits wide and wraps naturally
    localparam int ROWS = 8;

    // Colour sequence red -> green -> yellow -> red
    function automatic logic [1:0] next_color(input logic [1:0] c);
        return (c == COL_YELLOW) ? COL_RED : c + 2'd1;
    endfunction

endpackage

// File: rtl/dz_scan_cnt.sv
// Free-running row scan: divides clk by SCAN_DIV and steps a 3-bit row index.
// row_strobe is high for the cycle in which row_sel has just changed.
module dz_scan_cnt
    import dz_pkg::*;
#(
    parameter int SCAN_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] row_sel,
    output logic       row_strobe
);

    // SCAN_DIV=1 still needs a 1-bit counter; it simply stays at 0
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_cnt;
    logic          wrap;

    // Divider wraps on its last count; with SCAN_DIV=1 that is every cycle
    always_comb begin
        wrap = (scan_cnt == SCAN_LAST);
    end

    // Divider, row index and strobe; row index wraps after ROWS-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt   <= '0;
            row_sel    <= '0;
            row_strobe <= 1'b0;
        end else if (wrap) begin
            scan_cnt   <= '0;
            row_sel    <= (row_sel == 3'(ROWS - 1)) ? 3'd0 : row_sel + 3'd1;
            row_strobe <= 1'b1;
        end else begin
            scan_cnt   <= scan_cnt + CW'(1);
            row_strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/dz_count_ctrl.sv
// Countdown sequencer for the 8x8 red/green dot-matrix display.
// start loads START_VAL; the digit then steps down once every CLK_DIV_SEC
// cycles, cycling the colour phase on each step, until it reaches 0.
// The cycle after num reaches 0 the FSM moves to DONE and pulses done.
// pause freezes the countdown; the cycle pause drops also counts, so a pause
// held for N cycles delays every later step by exactly N cycles.
// start has priority over pause, tick and finishing.
// The FSM state is exported on the state port for observation.
module dz_count_ctrl
    import dz_pkg::*;
#(
    parameter int CLK_DIV_SEC = 1000,
    parameter int SCAN_DIV    = 8,
    parameter int START_VAL   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    output logic [2:0] num,
    output logic [1:0] color,
    output logic [2:0] row_sel,
    output logic       row_strobe,
    output logic       busy,
    output logic       done,
    output state_t     state
);

    localparam int SW = $clog2(CLK_DIV_SEC);
    localparam logic [SW-1:0] SEC_LAST  = SW'(CLK_DIV_SEC - 1);
    localparam logic [2:0]    LOAD_VAL  = 3'(START_VAL);

    logic [SW-1:0] sec_cnt;
    logic          tick;
    logic [SW-1:0] sec_step;
    logic [2:0]    num_step;
    logic [1:0]    color_step;

    // Values after one counting cycle; only used while num is non-zero
    always_comb begin
        tick       = (sec_cnt == SEC_LAST);
        sec_step   = sec_cnt + SW'(1);
        num_step   = num;
        color_step = color;
        if (tick) begin
            sec_step   = '0;
            num_step   = num - 3'd1;
            color_step = next_color(color);
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            num     <= 3'd0;
            color   <= COL_RED;
            sec_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state   <= RUN;
                num     <= LOAD_VAL;
                color   <= COL_RED;
                sec_cnt <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        if (num == 3'd0) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            sec_cnt <= '0;
                        end else if (pause) begin
                            state <= PAUSE;
                        end else begin
                            sec_cnt <= sec_step;
                            num     <= num_step;
                            color   <= color_step;
                        end
                    end
                    PAUSE: begin
                        if (!pause) begin
                            state   <= RUN;
                            sec_cnt <= sec_step;
                            num     <= num_step;
                            color   <= color_step;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    dz_scan_cnt #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .row_sel    (row_sel),
        .row_strobe (row_strobe)
    );

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Bench for dz_count_ctrl with CLK_DIV_SEC=4, SCAN_DIV=2, START_VAL=5.
module tb_dz_count_ctrl;
  import dz_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int SDIV    = 2;
  localparam int SVAL    = 5;
  localparam int K_END   = SVAL * CLK_DIV;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic pause;
  logic [2:0] num;
  logic [1:0] color;
  logic [2:0] row_sel;
  logic row_strobe;
  logic busy;
  logic done;
  state_t state;

  always #5 clk = ~clk;

  dz_count_ctrl #(
    .CLK_DIV_SEC (CLK_DIV),
    .SCAN_DIV    (SDIV),
    .START_VAL   (SVAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .num        (num),
    .color      (color),
    .row_sel    (row_sel),
    .row_strobe (row_strobe),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  typedef struct packed {
    state_t     st;
    logic [2:0] num;
    logic [1:0] color;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic s;
    logic p;
    exp_t e;
  } vec_t;

  // scoreboard
  logic [8:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int n_edges = 0;

  // countdown model: effective counting cycles since start
  logic m_active = 1'b0;
  logic m_paused = 1'b0;
  int   m_k = 0;

  function automatic exp_t mk_exp(state_t st, int n, int c, logic b, logic d);
    exp_t e;
    e.st = st;
    e.num = 3'(n);
    e.color = 2'(c);
    e.busy = b;
    e.done = d;
    return e;
  endfunction

  function automatic exp_t model_exp();
    if (!m_active)
      return mk_exp(IDLE, 0, 0, 1'b0, 1'b0);
    if (m_k <= K_END)
      return mk_exp(m_paused ? PAUSE : RUN, SVAL - m_k / CLK_DIV, (m_k / CLK_DIV) % 3, 1'b1, 1'b0);
    return mk_exp(DONE, 0, SVAL % 3, 1'b0, m_k == K_END + 1);
  endfunction

  task automatic check_ctrl(input string name);
    exp_t e;
    exp_t got;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_t'(exp_q.pop_front());
      got = {state, num, color, busy, done};
      if (got !== e) begin
        fails++;
        $display("FAIL %s @edge %0d: got st=%0d num=%0d col=%0d busy=%b done=%b, want st=%0d num=%0d col=%0d busy=%b done=%b",
                 name, n_edges, got.st, got.num, got.color, got.busy, got.done,
                 e.st, e.num, e.color, e.busy, e.done);
      end
    end
  endtask

  task automatic check_scan(input string name);
    logic [2:0] w_row;
    logic w_stb;
    w_row = 3'((n_edges / SDIV) % ROWS);
    w_stb = (n_edges > 0) && (n_edges % SDIV == 0);
    tests++;
    if (row_sel !== w_row || row_strobe !== w_stb) begin
      fails++;
      $display("FAIL %s scan @edge %0d: got row=%0d stb=%b, want row=%0d stb=%b",
               name, n_edges, row_sel, row_strobe, w_row, w_stb);
    end
  endtask

  // driver: called at negedge, applies inputs for one edge, checks after it
  task automatic drive(input logic s, input logic p, input exp_t e, input string name);
    start = s;
    pause = p;
    exp_q.push_back(e);
    @(posedge clk);
    n_edges++;
    @(negedge clk);
    check_ctrl(name);
    check_scan(name);
  endtask

  task automatic cyc(input logic s, input logic p, input string name);
    if (s) begin
      m_active = 1'b1;
      m_k = 0;
      m_paused = 1'b0;
    end else if (m_active) begin
      if (m_k >= K_END) begin
        if (m_k <= K_END + 1) m_k++;
      end else if (p) begin
        m_paused = 1'b1;
      end else begin
        m_paused = 1'b0;
        m_k++;
      end
    end
    drive(s, p, model_exp(), name);
  endtask

  task automatic do_reset();
    start = 1'b0;
    pause = 1'b0;
    rst = 1'b1;
    #1;
    n_edges = 0;
    exp_q.push_back(mk_exp(IDLE, 0, 0, 1'b0, 1'b0));
    check_ctrl("reset_async");
    check_scan("reset_async");
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(mk_exp(IDLE, 0, 0, 1'b0, 1'b0));
    check_ctrl("reset_hold");
    rst = 1'b0;
    m_active = 1'b0;
    m_paused = 1'b0;
    m_k = 0;
  endtask

  vec_t tbl[1:34];
  int chg[5] = '{14, 18, 22, 26, 30};

  initial begin
    // main countdown table: start sampled at edge 10, steps at edges 14..30,
    // done at edge 31
    for (int c = 1; c <= 34; c++) begin
      int m;
      m = 0;
      for (int j = 0; j < 5; j++) if (c >= chg[j]) m++;
      tbl[c].s = (c == 10);
      tbl[c].p = 1'b0;
      if (c < 10)       tbl[c].e = mk_exp(IDLE, 0, 0, 1'b0, 1'b0);
      else if (c <= 30) tbl[c].e = mk_exp(RUN, 5 - m, m % 3, 1'b1, 1'b0);
      else              tbl[c].e = mk_exp(DONE, 0, m % 3, 1'b0, c == 31);
    end

    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    do_reset();

    for (int c = 1; c <= 34; c++)
      drive(tbl[c].s, tbl[c].p, tbl[c].e, "table");
    m_active = 1'b1;
    m_k = K_END + 2;

    // pause for 7 cycles after the 4->3 step
    cyc(1'b1, 1'b0, "pause_start");
    repeat (8) cyc(1'b0, 1'b0, "pause_pre");
    repeat (7) cyc(1'b0, 1'b1, "pause_hold");
    repeat (16) cyc(1'b0, 1'b0, "pause_post");

    // restart while num=2, then start coinciding with a tick
    cyc(1'b1, 1'b0, "restart_start");
    repeat (12) cyc(1'b0, 1'b0, "restart_run");
    cyc(1'b1, 1'b0, "restart_num2");
    repeat (3) cyc(1'b0, 1'b0, "restart_run2");
    cyc(1'b1, 1'b0, "start_on_tick");
    repeat (23) cyc(1'b0, 1'b0, "restart_finish");

    // reset while paused with num=3
    cyc(1'b1, 1'b0, "rstp_start");
    repeat (8) cyc(1'b0, 1'b0, "rstp_run");
    repeat (2) cyc(1'b0, 1'b1, "rstp_pause");
    do_reset();

    // start and pause together from IDLE
    cyc(1'b1, 1'b1, "start_pause");
    repeat (3) cyc(1'b0, 1'b1, "sp_paused");
    repeat (23) cyc(1'b0, 1'b0, "sp_finish");

    // start from DONE reloads
    cyc(1'b1, 1'b0, "done_restart");
    repeat (5) cyc(1'b0, 1'b0, "done_restart_run");

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
